// File: rtl/riscv_multicycle_ctrl_if.sv
// Control/status bundle between the multi-cycle RV32I controller and its datapath.
// The master side is the controller; the slave side is the datapath that obeys it.
interface riscv_multicycle_ctrl_if;
  logic [31:0] Instr;
  logic        Zero;
  logic        Alu_Lsb;
  logic        Mem_Ready;
  logic        IR_Write;
  logic        PC_Write;
  logic [1:0]  PC_Src;
  logic        Target_Write;
  logic        Asel;
  logic        Bsel;
  logic [4:0]  ALU_Ctrl;
  logic        Reg_Write;
  logic [1:0]  WB_Sel;
  logic        Mem_Req;
  logic        Mem_We;
  logic        Mem_Addr_Sel;
  logic        Illegal;

  modport master (
    input  Instr, Zero, Alu_Lsb, Mem_Ready,
    output IR_Write, PC_Write, PC_Src, Target_Write, Asel, Bsel, ALU_Ctrl,
           Reg_Write, WB_Sel, Mem_Req, Mem_We, Mem_Addr_Sel, Illegal
  );

  modport slave (
    output Instr, Zero, Alu_Lsb, Mem_Ready,
    input  IR_Write, PC_Write, PC_Src, Target_Write, Asel, Bsel, ALU_Ctrl,
           Reg_Write, WB_Sel, Mem_Req, Mem_We, Mem_Addr_Sel, Illegal
  );
endinterface

// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing of the shared ALU,
// PC, IR, register file and memory port, with a memory-stall watchdog and sticky illegal trap.
module riscv_multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  riscv_multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [4:0] ALU_ADD  = 5'd1;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_AND  = 5'd7;
  localparam logic [4:0] ALU_SUB  = 5'd9;
  localparam logic [4:0] ALU_SLT  = 5'd10;
  localparam logic [4:0] ALU_SLTU = 5'd12;
  localparam logic [4:0] ALU_SLL  = 5'd17;
  localparam logic [4:0] ALU_SRL  = 5'd18;
  localparam logic [4:0] ALU_SRA  = 5'd19;

  localparam logic [1:0] PCS_SEQ  = 2'd0;
  localparam logic [1:0] PCS_TGT  = 2'd1;
  localparam logic [1:0] PCS_ALU  = 2'd2;
  localparam logic [1:0] WB_ALU   = 2'd0;
  localparam logic [1:0] WB_MEM   = 2'd1;
  localparam logic [1:0] WB_LINK  = 2'd2;
  localparam logic [1:0] WB_IMM   = 2'd3;

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  function automatic logic instr_legal(input logic [31:0] ins);
    logic [2:0] f3;
    logic [6:0] f7;
    logic       ok;
    f3 = ins[14:12];
    f7 = ins[31:25];
    ok = 1'b0;
    case (ins[6:0])
      OPC_OP:     ok = (f7 == 7'b0000000) ||
                       ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
      OPC_OP_IMM: begin
        case (f3)
          3'b001:  ok = (f7 == 7'b0000000);
          3'b101:  ok = (f7 == 7'b0000000) || (f7 == 7'b0100000);
          default: ok = 1'b1;
        endcase
      end
      OPC_LOAD:   ok = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
      OPC_STORE:  ok = (f3 < 3'b011);
      OPC_BRANCH: ok = (f3[2:1] != 2'b01);
      OPC_JALR:   ok = (f3 == 3'b000);
      OPC_JAL,
      OPC_LUI,
      OPC_AUIPC:  ok = 1'b1;
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Immediate forms never select SUB; bit 30 only distinguishes SRAI from SRLI there.
  function automatic logic [4:0] alu_op(input logic [31:0] ins, input logic reg_form);
    logic [4:0] code;
    case (ins[14:12])
      3'b000:  code = (reg_form && ins[30]) ? ALU_SUB : ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b010:  code = ALU_SLT;
      3'b011:  code = ALU_SLTU;
      3'b100:  code = ALU_XOR;
      3'b101:  code = ins[30] ? ALU_SRA : ALU_SRL;
      3'b110:  code = ALU_OR;
      default: code = ALU_AND;
    endcase
    return code;
  endfunction

  function automatic logic [4:0] branch_op(input logic [2:0] f3);
    logic [4:0] code;
    case (f3[2:1])
      2'b10:   code = ALU_SLT;
      2'b11:   code = ALU_SLTU;
      default: code = ALU_SUB;
    endcase
    return code;
  endfunction

  // funct3[0] inverts the sense: BNE/BGE/BGEU are the complements of BEQ/BLT/BLTU.
  function automatic logic branch_taken(input logic [2:0] f3, input logic zero,
                                        input logic lsb);
    logic flag;
    flag = f3[2] ? lsb : zero;
    return flag ^ f3[0];
  endfunction

  state_t     state;
  state_t     state_next;
  logic [7:0] tmo_cnt;
  logic [7:0] cnt_next;
  logic       mem_wait;
  logic       tmo_hit;
  logic [6:0] opc;
  logic [2:0] f3;
  logic       unused_instr_bits;

  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       target_write;
  logic       asel;
  logic       bsel;
  logic [4:0] alu_ctrl;
  logic       reg_write;
  logic [1:0] wb_sel;
  logic       mem_req;
  logic       mem_we;
  logic       mem_addr_sel;
  logic       illegal;

  assign opc               = bus.Instr[6:0];
  assign f3                = bus.Instr[14:12];
  assign unused_instr_bits = ^{bus.Instr[24:15], bus.Instr[11:7]};

  assign mem_wait = ((state == S_FETCH) || (state == S_MEM)) && !bus.Mem_Ready;
  assign tmo_hit  = mem_wait && (tmo_cnt == TMO_LAST);
  assign cnt_next = (mem_wait && !tmo_hit) ? tmo_cnt + 8'd1 : 8'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      tmo_cnt <= 8'd0;
    end else begin
      state   <= state_next;
      tmo_cnt <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: begin
        if (bus.Mem_Ready)  state_next = S_DECODE;
        else if (tmo_hit)   state_next = S_TRAP;
      end
      S_DECODE: state_next = instr_legal(bus.Instr) ? S_EXEC : S_TRAP;
      S_EXEC: begin
        case (opc)
          OPC_OP, OPC_OP_IMM, OPC_AUIPC: state_next = S_WB;
          OPC_LOAD, OPC_STORE:           state_next = S_MEM;
          default:                       state_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (bus.Mem_Ready)  state_next = (opc == OPC_STORE) ? S_FETCH : S_WB;
        else if (tmo_hit)   state_next = S_TRAP;
      end
      S_WB:     state_next = S_FETCH;
      S_TRAP:   state_next = S_TRAP;
      default:  state_next = S_FETCH;
    endcase
  end

  // Outputs are forced low while rst_n is held so a pending request drops without a clock.
  always_comb begin
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PCS_SEQ;
    target_write = 1'b0;
    asel         = 1'b0;
    bsel         = 1'b0;
    alu_ctrl     = 5'd0;
    reg_write    = 1'b0;
    wb_sel       = WB_ALU;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    illegal      = 1'b0;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          mem_req  = 1'b1;
          ir_write = bus.Mem_Ready;
          pc_write = bus.Mem_Ready;
        end
        S_DECODE: begin
          asel         = 1'b1;
          bsel         = 1'b1;
          alu_ctrl     = ALU_ADD;
          target_write = 1'b1;
        end
        S_EXEC: begin
          case (opc)
            OPC_OP:     alu_ctrl = alu_op(bus.Instr, 1'b1);
            OPC_OP_IMM: begin
              bsel     = 1'b1;
              alu_ctrl = alu_op(bus.Instr, 1'b0);
            end
            OPC_LOAD, OPC_STORE: begin
              bsel     = 1'b1;
              alu_ctrl = ALU_ADD;
            end
            OPC_BRANCH: begin
              alu_ctrl = branch_op(f3);
              if (branch_taken(f3, bus.Zero, bus.Alu_Lsb)) begin
                pc_write = 1'b1;
                pc_src   = PCS_TGT;
              end
            end
            OPC_JAL: begin
              pc_write  = 1'b1;
              pc_src    = PCS_TGT;
              reg_write = 1'b1;
              wb_sel    = WB_LINK;
            end
            OPC_JALR: begin
              bsel      = 1'b1;
              alu_ctrl  = ALU_ADD;
              pc_write  = 1'b1;
              pc_src    = PCS_ALU;
              reg_write = 1'b1;
              wb_sel    = WB_LINK;
            end
            OPC_LUI: begin
              reg_write = 1'b1;
              wb_sel    = WB_IMM;
            end
            OPC_AUIPC: begin
              asel     = 1'b1;
              bsel     = 1'b1;
              alu_ctrl = ALU_ADD;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = (opc == OPC_STORE);
          bsel         = 1'b1;
          alu_ctrl     = ALU_ADD;
        end
        S_WB: begin
          reg_write = 1'b1;
          wb_sel    = (opc == OPC_LOAD) ? WB_MEM : WB_ALU;
        end
        S_TRAP:  illegal = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.IR_Write     = ir_write;
  assign bus.PC_Write     = pc_write;
  assign bus.PC_Src       = pc_src;
  assign bus.Target_Write = target_write;
  assign bus.Asel         = asel;
  assign bus.Bsel         = bsel;
  assign bus.ALU_Ctrl     = alu_ctrl;
  assign bus.Reg_Write    = reg_write;
  assign bus.WB_Sel       = wb_sel;
  assign bus.Mem_Req      = mem_req;
  assign bus.Mem_We       = mem_we;
  assign bus.Mem_Addr_Sel = mem_addr_sel;
  assign bus.Illegal      = illegal;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Directed bench for riscv_multicycle_ctrl: an instruction-level model expands each
// instruction into its expected per-cycle control vectors, checked every cycle.
`timescale 1ns/1ps
module tb_riscv_multicycle_ctrl;
  localparam int TMO = 4;

  typedef struct packed {
    logic       ir_w;
    logic       pc_w;
    logic [1:0] pc_src;
    logic       tgt_w;
    logic       asel;
    logic       bsel;
    logic [4:0] alu;
    logic       reg_w;
    logic [1:0] wb_sel;
    logic       mem_req;
    logic       mem_we;
    logic       mem_sel;
    logic       illegal;
  } outs_t;

  typedef struct {
    outs_t       o;
    logic [31:0] ins;
    logic        rdy;
    logic        z;
    logic        lsb;
  } cyc_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          checks = 0;
  int          fails = 0;
  cyc_t        plan[$];
  outs_t       got[$];
  outs_t       exp_cur;
  logic        chk_en = 1'b0;
  logic [31:0] cur_ins;
  logic        cur_z;
  logic        cur_lsb;

  riscv_multicycle_ctrl_if bus();

  riscv_multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic outs_t sample();
    outs_t s;
    s.ir_w    = bus.IR_Write;
    s.pc_w    = bus.PC_Write;
    s.pc_src  = bus.PC_Src;
    s.tgt_w   = bus.Target_Write;
    s.asel    = bus.Asel;
    s.bsel    = bus.Bsel;
    s.alu     = bus.ALU_Ctrl;
    s.reg_w   = bus.Reg_Write;
    s.wb_sel  = bus.WB_Sel;
    s.mem_req = bus.Mem_Req;
    s.mem_we  = bus.Mem_We;
    s.mem_sel = bus.Mem_Addr_Sel;
    s.illegal = bus.Illegal;
    return s;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      outs_t a;
      a = sample();
      got.push_back(a);
      checks++;
      if (a !== exp_cur) begin
        fails++;
        $display("FAIL cycle%0d ins=%h: got %b required %b", got.size() - 1, bus.Instr, a, exp_cur);
      end
    end
  end

  task automatic pin(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  // ---------------- instruction-level model ----------------
  function automatic string classify(input logic [31:0] ins);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = ins[14:12];
    f7 = ins[31:25];
    case (ins[6:0])
      7'h33: return (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) ? "OP" : "ILL";
      7'h13: begin
        if (f3 == 3'd1) return (f7 == 7'h00) ? "OPI" : "ILL";
        if (f3 == 3'd5) return (f7 == 7'h00 || f7 == 7'h20) ? "OPI" : "ILL";
        return "OPI";
      end
      7'h03: return (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ? "LD" : "ILL";
      7'h23: return (f3 inside {3'd0, 3'd1, 3'd2}) ? "ST" : "ILL";
      7'h63: return (f3 inside {3'd2, 3'd3}) ? "ILL" : "BR";
      7'h6F: return "JAL";
      7'h67: return (f3 == 3'd0) ? "JALR" : "ILL";
      7'h37: return "LUI";
      7'h17: return "AUIPC";
      default: return "ILL";
    endcase
  endfunction

  function automatic logic [4:0] alu_of(input logic [31:0] ins, input bit reg_form);
    logic [4:0] base[8];
    logic [4:0] c;
    base = '{5'd1, 5'd17, 5'd10, 5'd12, 5'd5, 5'd18, 5'd3, 5'd7};
    c = base[ins[14:12]];
    if (ins[14:12] == 3'd5 && ins[30]) c = 5'd19;
    if (reg_form && ins[14:12] == 3'd0 && ins[30]) c = 5'd9;
    return c;
  endfunction

  task automatic add(input outs_t o, input logic rdy);
    cyc_t c;
    c.o = o; c.ins = cur_ins; c.rdy = rdy; c.z = cur_z; c.lsb = cur_lsb;
    plan.push_back(c);
  endtask

  task automatic add_trap(input int n);
    outs_t o;
    o = '0;
    o.illegal = 1'b1;
    for (int i = 0; i < n; i++) add(o, 1'b0);
  endtask

  task automatic plan_instr(input logic [31:0] ins, input int fw, input int mw,
                            input logic z, input logic lsb);
    outs_t o;
    string cls;
    logic  taken;
    cur_ins = ins; cur_z = z; cur_lsb = lsb;
    for (int i = 0; i < fw && i < TMO; i++) begin
      o = '0; o.mem_req = 1'b1; add(o, 1'b0);
    end
    if (fw >= TMO) begin add_trap(3); return; end
    o = '0; o.mem_req = 1'b1; o.ir_w = 1'b1; o.pc_w = 1'b1; add(o, 1'b1);
    o = '0; o.asel = 1'b1; o.bsel = 1'b1; o.alu = 5'd1; o.tgt_w = 1'b1; add(o, 1'b0);
    cls = classify(ins);
    o = '0;
    if (cls == "ILL") begin
      add_trap(3);
    end else if (cls == "OP" || cls == "OPI" || cls == "AUIPC") begin
      if (cls == "OP")  o.alu = alu_of(ins, 1'b1);
      if (cls == "OPI") begin o.bsel = 1'b1; o.alu = alu_of(ins, 1'b0); end
      if (cls == "AUIPC") begin o.asel = 1'b1; o.bsel = 1'b1; o.alu = 5'd1; end
      add(o, 1'b0);
      o = '0; o.reg_w = 1'b1; add(o, 1'b0);
    end else if (cls == "LD" || cls == "ST") begin
      o.bsel = 1'b1; o.alu = 5'd1; add(o, 1'b0);
      o.mem_req = 1'b1; o.mem_sel = 1'b1; o.mem_we = (cls == "ST");
      for (int i = 0; i < mw; i++) add(o, 1'b0);
      add(o, 1'b1);
      if (cls == "LD") begin
        o = '0; o.reg_w = 1'b1; o.wb_sel = 2'd1; add(o, 1'b0);
      end
    end else if (cls == "BR") begin
      case (ins[14:12])
        3'd0:    begin o.alu = 5'd9;  taken = z;    end
        3'd1:    begin o.alu = 5'd9;  taken = !z;   end
        3'd4:    begin o.alu = 5'd10; taken = lsb;  end
        3'd5:    begin o.alu = 5'd10; taken = !lsb; end
        3'd6:    begin o.alu = 5'd12; taken = lsb;  end
        default: begin o.alu = 5'd12; taken = !lsb; end
      endcase
      if (taken) begin o.pc_w = 1'b1; o.pc_src = 2'd1; end
      add(o, 1'b0);
    end else if (cls == "JAL") begin
      o.pc_w = 1'b1; o.pc_src = 2'd1; o.reg_w = 1'b1; o.wb_sel = 2'd2; add(o, 1'b0);
    end else if (cls == "JALR") begin
      o.bsel = 1'b1; o.alu = 5'd1; o.pc_w = 1'b1; o.pc_src = 2'd2;
      o.reg_w = 1'b1; o.wb_sel = 2'd2; add(o, 1'b0);
    end else begin
      o.reg_w = 1'b1; o.wb_sel = 2'd3; add(o, 1'b0);
    end
  endtask

  // ---------------- drivers ----------------
  // Entered and left at posedge+1; inputs for a cycle are applied there.
  task automatic play(input int n);
    int k;
    k = 0;
    while (plan.size() > 0 && (n < 0 || k < n)) begin
      cyc_t c;
      c = plan.pop_front();
      bus.Instr = c.ins; bus.Zero = c.z; bus.Alu_Lsb = c.lsb; bus.Mem_Ready = c.rdy;
      exp_cur = c.o;
      chk_en = 1'b1;
      @(negedge clk);
      #1 chk_en = 1'b0;
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  task automatic run(input logic [31:0] ins, input int fw, input int mw,
                     input logic z, input logic lsb);
    got.delete();
    plan_instr(ins, fw, mw, z, lsb);
    play(-1);
  endtask

  task automatic do_reset(input string nm);
    outs_t zero_o;
    zero_o = '0;
    chk_en = 1'b0;
    plan.delete();
    rst_n = 1'b0;
    bus.Mem_Ready = 1'b0;
    #1;
    pin({nm, "_immediate"}, 32'(sample()), 32'(zero_o));
    bus.Mem_Ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    pin({nm, "_held"}, 32'(sample()), 32'(zero_o));
    bus.Mem_Ready = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.Instr = 32'h0; bus.Zero = 1'b0; bus.Alu_Lsb = 1'b0; bus.Mem_Ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset("reset");

    run(32'h002081B3, 0, 0, 1'b0, 1'b0);              // ADD x3,x1,x2
    pin("add_fetch_irw", 32'(got[0].ir_w), 32'd1);
    pin("add_exec_alu", 32'(got[2].alu), 32'd1);
    pin("add_exec_bsel", 32'(got[2].bsel), 32'd0);
    pin("add_wb_regw", 32'(got[3].reg_w), 32'd1);

    run(32'h4032D293, 1, 0, 1'b0, 1'b0);              // SRAI x5,x5,3
    pin("srai_alu", 32'(got[3].alu), 32'd19);
    pin("srai_bsel", 32'(got[3].bsel), 32'd1);

    run(32'h40008093, 0, 0, 1'b0, 1'b0);              // ADDI imm with bit30 set
    pin("addi_not_sub", 32'(got[2].alu), 32'd1);

    run(32'h402081B3, 0, 0, 1'b0, 1'b0);              // SUB
    pin("sub_alu", 32'(got[2].alu), 32'd9);
    run(32'h0020B1B3, 0, 0, 1'b0, 1'b0);              // SLTU
    run(32'h0020F1B3, 0, 0, 1'b0, 1'b0);              // AND
    run(32'h4020D1B3, 0, 0, 1'b0, 1'b0);              // SRA
    run(32'h002091B3, 0, 0, 1'b0, 1'b0);              // SLL
    run(32'h0030E093, 0, 0, 1'b0, 1'b0);              // ORI
    pin("ori_alu", 32'(got[2].alu), 32'd3);

    run(32'h00209463, 0, 0, 1'b0, 1'b0);              // BNE, Zero=0 -> taken
    pin("bne_taken_pcw", 32'(got[2].pc_w), 32'd1);
    pin("bne_taken_src", 32'(got[2].pc_src), 32'd1);
    pin("bne_len", 32'(got.size()), 32'd3);
    run(32'h00209463, 0, 0, 1'b1, 1'b0);              // BNE, Zero=1 -> not taken
    pin("bne_nt_pcw", 32'(got[2].pc_w), 32'd0);
    run(32'h00208463, 0, 0, 1'b1, 1'b0);              // BEQ taken
    run(32'h0020C463, 0, 0, 1'b0, 1'b1);              // BLT taken
    run(32'h0020F463, 0, 0, 1'b0, 1'b1);              // BGEU not taken
    pin("bgeu_alu", 32'(got[2].alu), 32'd12);

    run(32'h0000A283, 1, 3, 1'b0, 1'b0);              // LW, 3 MEM wait cycles
    pin("lw_memreq_first", 32'(got[4].mem_req), 32'd1);
    pin("lw_memreq_last", 32'(got[7].mem_req), 32'd1);
    pin("lw_wb_sel", 32'(got[8].wb_sel), 32'd1);
    pin("lw_wb_regw", 32'(got[8].reg_w), 32'd1);
    run(32'h0020A223, 0, 1, 1'b0, 1'b0);              // SW
    pin("sw_we", 32'(got[3].mem_we), 32'd1);
    run(32'h008000EF, 0, 0, 1'b0, 1'b0);              // JAL
    run(32'h000080E7, 0, 0, 1'b0, 1'b0);              // JALR
    pin("jalr_src", 32'(got[2].pc_src), 32'd2);
    run(32'h123452B7, 0, 0, 1'b0, 1'b0);              // LUI
    pin("lui_wb_sel", 32'(got[2].wb_sel), 32'd3);
    run(32'h00001297, 2, 0, 1'b0, 1'b0);              // AUIPC
    pin("auipc_len", 32'(got.size()), 32'd6);

    // Reset asserted while a load waits in MEM.
    got.delete();
    plan_instr(32'h0000A283, 0, 2, 1'b0, 1'b0);
    play(4);
    pin("mid_mem_req", 32'(bus.Mem_Req), 32'd1);
    do_reset("rst_mid_mem");
    run(32'h002081B3, 0, 0, 1'b0, 1'b0);

    // Fetch never completes.
    run(32'h002081B3, 10, 0, 1'b0, 1'b0);
    pin("tmo_stall4_req", 32'(got[3].mem_req), 32'd1);
    pin("tmo_trap", 32'(got[4].illegal), 32'd1);
    do_reset("rst_after_tmo");

    run(32'h0000007F, 0, 0, 1'b0, 1'b0);              // unsupported opcode
    pin("ill_decode_tgtw", 32'(got[1].tgt_w), 32'd1);
    pin("ill_trap", 32'(got[2].illegal), 32'd1);
    do_reset("rst_after_ill");

    run(32'h022081B3, 0, 0, 1'b0, 1'b0);              // MUL is not supported
    pin("mul_trap", 32'(got[3].illegal), 32'd1);
    do_reset("rst_final");
    run(32'h0000A283, 0, 0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end
endmodule
